// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert red-ball layer: game/spawn FSM
// encodings and the LFSR polynomial used to draw descent paths.
package qbert_pkg;

    typedef enum logic [1:0] {
        OFF,
        RUN,
        PAUSE
    } game_state_t;

    typedef enum logic [1:0] {
        WAIT,
        ARM,
        ACTIVE
    } spawn_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One right shift of a 16-bit Galois LFSR with the taps in LFSR_MASK.
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
    endfunction

endpackage

// File: rtl/boule_rouge_spawner_if.sv
// Spawn handshake between the red-ball spawner (master) and the red-ball
// layer (slave): request/path/position one way, acknowledge/end the other.
interface boule_rouge_spawner_if;

    logic        e_enable_br;
    logic [5:0]  e_move_br;
    logic [20:0] e_XY0_br;
    logic        done_move_br;
    logic        br_end;

    modport master (
        output e_enable_br,
        output e_move_br,
        output e_XY0_br,
        input  done_move_br,
        input  br_end
    );

    modport slave (
        input  e_enable_br,
        input  e_move_br,
        input  e_XY0_br,
        output done_move_br,
        output br_end
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the
// register never locks up in the all-zero state.
module lfsr16
    import qbert_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q_reg <= lfsr_next(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/boule_rouge_spawner.sv
// Red-ball spawn sequencer: follows game start/pause/resume, waits a
// programmable delay, offers a ball with a random path, and re-arms on ball end.
module boule_rouge_spawner
    import qbert_pkg::*;
#(
    parameter logic [31:0] SPAWN_DELAY = 32'd100_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [10:0] TOP_X       = 11'd400,
    parameter logic [9:0]  TOP_Y       = 10'd240
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         e_start_qb,
    input  logic                         e_pause_qb,
    input  logic                         e_resume_qb,
    input  logic [10:0]                  XDIAG_DEMI,
    input  logic [10:0]                  XLENGTH,
    input  logic [9:0]                   YDIAG_DEMI,
    boule_rouge_spawner_if.master        bus,
    output logic [7:0]                   spawn_cnt,
    output logic                         spawner_busy
);

    // A zero delay is treated as one cycle.
    localparam logic [31:0] DELAY_LAST = (SPAWN_DELAY == 32'd0) ? 32'd0 : SPAWN_DELAY - 32'd1;

    game_state_t  game_reg,  game_next;
    spawn_state_t spawn_reg, spawn_next;
    logic [31:0]  cnt_reg, cnt_next;
    logic         br_prev_reg, br_prev_next;
    logic         enable_reg, enable_next;
    logic [5:0]   move_reg, move_next;
    logic [20:0]  xy_reg, xy_next;
    logic [7:0]   spawn_cnt_reg, spawn_cnt_next;
    logic         busy_reg, busy_next;

    logic         restart;
    logic         advance;
    logic [15:0]  lfsr_q;
    logic [10:0]  spawn_x;
    logic [9:0]   spawn_y_up;
    logic [9:0]   spawn_y_dn;
    logic         unused_lfsr_bits;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[15:7];

    // Positions wrap naturally at the field widths.
    assign spawn_x    = TOP_X + XDIAG_DEMI + XLENGTH;
    assign spawn_y_up = TOP_Y - YDIAG_DEMI;
    assign spawn_y_dn = TOP_Y + YDIAG_DEMI;

    always_comb begin
        game_next      = game_reg;
        spawn_next     = spawn_reg;
        cnt_next       = cnt_reg;
        br_prev_next   = br_prev_reg;
        enable_next    = enable_reg;
        move_next      = move_reg;
        xy_next        = xy_reg;
        spawn_cnt_next = spawn_cnt_reg;
        restart        = 1'b0;
        advance        = 1'b0;

        case (game_reg)
            OFF: begin
                if (e_start_qb || e_resume_qb) begin
                    game_next = RUN;
                    restart   = 1'b1;
                end
            end
            RUN: begin
                if (e_start_qb) begin
                    restart = 1'b1;
                end else if (e_pause_qb) begin
                    game_next = PAUSE;
                end else begin
                    advance = 1'b1;
                end
            end
            PAUSE: begin
                if (e_start_qb) begin
                    game_next = RUN;
                    restart   = 1'b1;
                end else if (e_resume_qb) begin
                    game_next = RUN;
                end
            end
            default: game_next = OFF;
        endcase

        if (restart) begin
            spawn_next     = WAIT;
            cnt_next       = '0;
            spawn_cnt_next = '0;
            enable_next    = 1'b0;
        end else if (advance) begin
            // The edge register only moves while the spawn FSM moves, so an
            // end that arrives during a pause is still seen on resume.
            br_prev_next = bus.br_end;
            case (spawn_reg)
                WAIT: begin
                    if (cnt_reg == DELAY_LAST) begin
                        cnt_next    = '0;
                        spawn_next  = ARM;
                        enable_next = 1'b1;
                        move_next   = lfsr_q[5:0];
                        xy_next     = {spawn_x, lfsr_q[6] ? spawn_y_dn : spawn_y_up};
                    end else begin
                        cnt_next = cnt_reg + 32'd1;
                    end
                end
                ARM: begin
                    if (bus.done_move_br) begin
                        enable_next = 1'b0;
                        spawn_next  = ACTIVE;
                        if (spawn_cnt_reg != 8'hFF) begin
                            spawn_cnt_next = spawn_cnt_reg + 8'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (bus.br_end && !br_prev_reg) begin
                        spawn_next = WAIT;
                    end
                end
                default: spawn_next = WAIT;
            endcase
        end

        busy_next = (spawn_next != WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            game_reg      <= OFF;
            spawn_reg     <= WAIT;
            cnt_reg       <= '0;
            br_prev_reg   <= 1'b0;
            enable_reg    <= 1'b0;
            move_reg      <= '0;
            xy_reg        <= '0;
            spawn_cnt_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            game_reg      <= game_next;
            spawn_reg     <= spawn_next;
            cnt_reg       <= cnt_next;
            br_prev_reg   <= br_prev_next;
            enable_reg    <= enable_next;
            move_reg      <= move_next;
            xy_reg        <= xy_next;
            spawn_cnt_reg <= spawn_cnt_next;
            busy_reg      <= busy_next;
        end
    end

    assign bus.e_enable_br = enable_reg;
    assign bus.e_move_br   = move_reg;
    assign bus.e_XY0_br    = xy_reg;
    assign spawn_cnt       = spawn_cnt_reg;
    assign spawner_busy    = busy_reg;

endmodule

// File: tb/tb_boule_rouge_spawner.sv
// Bench for boule_rouge_spawner: directed timing steps plus random traffic,
// all compared against a countdown-based behavioural model of the spawner.
module tb_boule_rouge_spawner;

    localparam int DEL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        start = 1'b0, pause = 1'b0, resume = 1'b0;
    logic        done = 1'b0, bre = 1'b0;
    logic        start0 = 1'b0, tie0 = 1'b0, done0 = 1'b0, bre0 = 1'b0;
    logic [10:0] xdiag = 11'd40, xlen = 11'd20;
    logic [9:0]  ydiag = 10'd30;
    logic [7:0]  cnt, cnt0;
    logic        busy, busy0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    boule_rouge_spawner_if bus ();
    boule_rouge_spawner_if bus0 ();

    assign bus.done_move_br  = done;
    assign bus.br_end        = bre;
    assign bus0.done_move_br = done0;
    assign bus0.br_end       = bre0;

    boule_rouge_spawner #(
        .SPAWN_DELAY (32'd8),
        .LFSR_SEED   (16'hACE1),
        .TOP_X       (11'd400),
        .TOP_Y       (10'd240)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .e_start_qb   (start),
        .e_pause_qb   (pause),
        .e_resume_qb  (resume),
        .XDIAG_DEMI   (xdiag),
        .XLENGTH      (xlen),
        .YDIAG_DEMI   (ydiag),
        .bus          (bus),
        .spawn_cnt    (cnt),
        .spawner_busy (busy)
    );

    boule_rouge_spawner #(
        .SPAWN_DELAY (32'd0),
        .LFSR_SEED   (16'h0000),
        .TOP_X       (11'd400),
        .TOP_Y       (10'd240)
    ) u_fast (
        .clk          (clk),
        .reset        (reset),
        .e_start_qb   (start0),
        .e_pause_qb   (tie0),
        .e_resume_qb  (tie0),
        .XDIAG_DEMI   (xdiag),
        .XLENGTH      (xlen),
        .YDIAG_DEMI   (ydiag),
        .bus          (bus0),
        .spawn_cnt    (cnt0),
        .spawner_busy (busy0)
    );

    // Behavioural model: on/paused flags, a phase number and a countdown
    // of running cycles left before the next ball is offered.
    bit          m_on, m_paused, m_last_br, go, fresh;
    int          m_phase, m_left, m_cnt;
    logic        m_en;
    logic [5:0]  m_move;
    logic [20:0] m_xy;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        go = 1'b0;
        fresh = 1'b0;
        if (!reset) begin
            m_on = 1'b0; m_paused = 1'b0; m_last_br = 1'b0;
            m_phase = 0; m_left = DEL; m_cnt = 0;
            m_en = 1'b0; m_move = '0; m_xy = '0;
            m_lfsr = 16'hACE1;
        end else begin
            if (!m_on) begin
                if (start || resume) begin m_on = 1'b1; fresh = 1'b1; end
            end else if (m_paused) begin
                if (start) begin m_paused = 1'b0; fresh = 1'b1; end
                else if (resume) m_paused = 1'b0;
            end else if (start) fresh = 1'b1;
            else if (pause) m_paused = 1'b1;
            else go = 1'b1;

            if (fresh) begin
                m_phase = 0; m_left = DEL; m_cnt = 0; m_en = 1'b0;
            end else if (go) begin
                if (m_phase == 0) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = 1;
                        m_en = 1'b1;
                        m_move = m_lfsr[5:0];
                        m_xy[20:10] = 11'(400 + int'(xdiag) + int'(xlen));
                        m_xy[9:0] = m_lfsr[6] ? 10'(240 + int'(ydiag)) : 10'(240 - int'(ydiag));
                    end
                end else if (m_phase == 1) begin
                    if (done) begin
                        m_phase = 2; m_en = 1'b0;
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                    end
                end else if (bre && !m_last_br) begin
                    m_phase = 0; m_left = DEL;
                end
                m_last_br = bre;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_en"},   32'(bus.e_enable_br), 32'(m_en));
        chk({tag, "_move"}, 32'(bus.e_move_br),   32'(m_move));
        chk({tag, "_xy"},   32'(bus.e_XY0_br),    32'(m_xy));
        chk({tag, "_cnt"},  32'(cnt),             32'(m_cnt));
        chk({tag, "_busy"}, 32'(busy),            32'(m_phase != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            tick();
            check_all("dir");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] snap;
    logic [20:0] xy_exp;

    initial begin
        run_to(3);
        chk("rst_en",   32'(bus.e_enable_br), 32'd0);
        chk("rst_move", 32'(bus.e_move_br),   32'd0);
        chk("rst_xy",   32'(bus.e_XY0_br),    32'd0);
        chk("rst_cnt",  32'(cnt),             32'd0);
        chk("rst_busy", 32'(busy),            32'd0);
        reset = 1'b1;

        // First spawn: start at edge 10, offer at edge 18.
        run_to(9);  start = 1'b1;
        run_to(10); start = 1'b0;
        run_to(17);
        chk("pre_en", 32'(bus.e_enable_br), 32'd0);
        snap = m_lfsr;
        run_to(18);
        chk("en_rise", 32'(bus.e_enable_br), 32'd1);
        xy_exp = snap[6] ? {11'd460, 10'd270} : {11'd460, 10'd210};
        chk("xy_first",   32'(bus.e_XY0_br),  32'(xy_exp));
        chk("move_first", 32'(bus.e_move_br), 32'(snap[5:0]));
        run_to(20); bre = 1'b1;
        run_to(22); done = 1'b1;
        run_to(23); done = 1'b0;
        chk("ack_en",  32'(bus.e_enable_br), 32'd0);
        chk("ack_cnt", 32'(cnt), 32'd1);

        // br_end held high before ACTIVE must not count; rise at edge 100 does.
        run_to(30); bre = 1'b0;
        run_to(99);
        chk("held_busy", 32'(busy), 32'd1);
        bre = 1'b1;
        run_to(100);
        chk("end_busy", 32'(busy), 32'd0);
        run_to(107);
        chk("re_pre", 32'(bus.e_enable_br), 32'd0);
        run_to(108);
        chk("re_rise", 32'(bus.e_enable_br), 32'd1);
        run_to(110); done = 1'b1;
        run_to(111); done = 1'b0; bre = 1'b0;

        // 20 non-running edges in mid-WAIT push the offer from 128 to 148.
        run_to(119); bre = 1'b1;
        run_to(122); pause = 1'b1;
        run_to(123); pause = 1'b0;
        run_to(125); bre = 1'b0;
        run_to(141); resume = 1'b1;
        run_to(142); resume = 1'b0;
        run_to(147);
        chk("pause_pre", 32'(bus.e_enable_br), 32'd0);
        run_to(148);
        chk("pause_rise", 32'(bus.e_enable_br), 32'd1);

        // Acknowledge during pause is ignored until resume.
        run_to(150); pause = 1'b1;
        run_to(151); pause = 1'b0;
        run_to(152); done = 1'b1;
        run_to(155);
        chk("arm_pause_en",  32'(bus.e_enable_br), 32'd1);
        chk("arm_pause_cnt", 32'(cnt), 32'd2);
        run_to(160); resume = 1'b1;
        run_to(161); resume = 1'b0;
        chk("resume_en", 32'(bus.e_enable_br), 32'd1);
        run_to(162); done = 1'b0;
        chk("late_ack_en",  32'(bus.e_enable_br), 32'd0);
        chk("late_ack_cnt", 32'(cnt), 32'd3);

        // Start while ACTIVE restarts; reset mid-ARM clears everything.
        run_to(170); start = 1'b1;
        run_to(171); start = 1'b0;
        chk("restart_cnt",  32'(cnt), 32'd0);
        chk("restart_busy", 32'(busy), 32'd0);
        run_to(178);
        chk("restart_pre", 32'(bus.e_enable_br), 32'd0);
        run_to(179);
        chk("restart_rise", 32'(bus.e_enable_br), 32'd1);
        run_to(181); reset = 1'b0;
        run_to(182); reset = 1'b1;
        chk("rst2_en",   32'(bus.e_enable_br), 32'd0);
        chk("rst2_move", 32'(bus.e_move_br),   32'd0);
        chk("rst2_xy",   32'(bus.e_XY0_br),    32'd0);
        chk("rst2_cnt",  32'(cnt),             32'd0);
        chk("rst2_busy", 32'(busy),            32'd0);

        // Random traffic, including geometry that wraps the position fields.
        for (int i = 0; i < 1500; i++) begin
            start  = ($urandom_range(0, 59) == 0);
            pause  = ($urandom_range(0, 29) == 0);
            resume = ($urandom_range(0, 7) == 0);
            done   = ($urandom_range(0, 2) == 0);
            bre    = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) begin
                xdiag = 11'($urandom_range(0, 2047));
                xlen  = 11'($urandom_range(0, 2047));
                ydiag = 10'($urandom_range(0, 1023));
            end
            tick();
            check_all("rnd");
        end
        start = 1'b0; pause = 1'b0; resume = 1'b0; done = 1'b0; bre = 1'b0;
        reset = 1'b1;

        // Zero delay acts as one cycle; the spawn count saturates at 255.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("fast_wait", 32'(bus0.e_enable_br), 32'd0);
        tick();
        chk("fast_en", 32'(bus0.e_enable_br), 32'd1);
        for (int i = 1; i <= 300; i++) begin
            int guard = 0;
            while (!bus0.e_enable_br && guard < 8) begin
                tick();
                guard++;
            end
            chk("fast_arm", 32'(bus0.e_enable_br), 32'd1);
            done0 = 1'b1;
            tick();
            done0 = 1'b0;
            chk("sat_cnt", 32'(cnt0), (i > 255) ? 32'd255 : 32'(i));
            bre0 = 1'b1;
            tick();
            bre0 = 1'b0;
            tick();
        end
        chk("fast_busy", 32'(busy0), 32'd1);
        check_all("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boule_rouge_spawner.md
# boule_rouge_spawner

Upstream sequencer for the red-ball layer. Decides when a red ball appears and on which row-2 cube, draws its 6-move descent path from an LFSR, and drives `e_enable_br`, `e_move_br` and `e_XY0_br` through an enable/acknowledge handshake. It follows game start/pause/resume, waits for the current ball to finish (`br_end`), then re-arms after a programmable delay.

## Interface
- `SPAWN_DELAY`, 32'd100_000_000: cycles between a ball's end (or game start) and the next enable.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- `TOP_X`, 11'd400: x of the top cube centre.
- `TOP_Y`, 10'd240: y of the top cube centre.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `e_start_qb`, `e_pause_qb`, `e_resume_qb` in 1 each: game-state controls, level-sampled.
- `XDIAG_DEMI` in 11, `XLENGTH` in 11, `YDIAG_DEMI` in 10: cube geometry.
- `done_move_br` in 1: acknowledge from the layer, high once the ball has slid in.
- `br_end` in 1: the layer's ball has finished.
- `e_enable_br` out 1: spawn request, held until acknowledged.
- `e_move_br` out 6: path bits; bit *i* is move *i+1*; 0 = up-diagonal (y−), 1 = down-diagonal (y+).
- `e_XY0_br` out 21: spawn position, {x[10:0], y[9:0]}.
- `spawn_cnt` out 8: balls spawned since start, saturating at 255.
- `spawner_busy` out 1: high in ARM or ACTIVE.

## Operation
- Game FSM states:
  - OFF (after reset): `e_start_qb | e_resume_qb` → RUN, with the spawn FSM in WAIT and the counter at 0.
  - RUN: `e_pause_qb` → PAUSE.
  - PAUSE: `e_resume_qb` → RUN, state and counter kept; `e_start_qb` → RUN, spawn FSM restarted.
  - In RUN, `e_start_qb` also restarts the spawn FSM and clears `spawn_cnt`.
- Spawn FSM advances only in RUN. All registers hold in PAUSE and OFF.
  - WAIT: counter increments each cycle. When `cnt == SPAWN_DELAY-1`, clear the counter and go to ARM.
  - On the WAIT→ARM edge: latch `e_move_br <= lfsr[5:0]`, set side `s = lfsr[6]`, latch `e_XY0_br`, set `e_enable_br <= 1`.
  - ARM: hold all outputs stable. When `done_move_br == 1`: `e_enable_br <= 0`, increment `spawn_cnt` (saturating), go to ACTIVE.
  - ACTIVE: a 0→1 edge on `br_end`, using a registered previous value, goes to WAIT. A `br_end` already high on entry does not count as an end.
- Spawn position:
  - x = TOP_X + XDIAG_DEMI + XLENGTH.
  - y = TOP_Y − YDIAG_DEMI if s=0, TOP_Y + YDIAG_DEMI if s=1.
  - Both are computed modulo 2^11 / 2^10; no saturation.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle regardless of game state. Only `reset` reloads it.
- If a start restart occurs during ARM, `e_enable_br` drops on the next edge.
- `SPAWN_DELAY == 0` behaves as 1.

## Timing
- Reset values:
  - Game FSM = OFF, spawn FSM = WAIT.
  - `e_enable_br = 0`, `e_move_br = 0`, `e_XY0_br = 0`, `spawn_cnt = 0`, `spawner_busy = 0`.
  - LFSR = seed; counter = 0; registered `br_end` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start sampled at edge *t* → WAIT at count 0 from *t+1* → `e_enable_br` high from edge *t+SPAWN_DELAY*.
- `done_move_br` sampled high at edge *a* → `e_enable_br` low and `spawn_cnt` incremented from *a+1*.
- `br_end` rise sampled at edge *b* → WAIT from *b+1*; the next enable is high from *b+SPAWN_DELAY*.
- Simultaneous events:
  - `e_pause_qb` wins over `done_move_br` and `br_end`. Missed acknowledges remain visible as levels after resume.
  - A `br_end` edge that occurs while paused is detected on resume, because the edge register also holds during pause.
  - `reset` low wins over everything.

## Structure
- Shared package `qbert_pkg`:
  - `game_state_t {OFF, RUN, PAUSE}`.
  - `spawn_state_t {WAIT, ARM, ACTIVE}`.
  - Constant `LFSR_MASK = 16'hB400`.
- Sub-module `lfsr16`: ports `clk`, `reset`, `seed`, `q[15:0]`.

## Test plan
Common setup: SPAWN_DELAY=8, TOP_X=400, TOP_Y=240, XDIAG_DEMI=40, XLENGTH=20, YDIAG_DEMI=30.
- Start pulse at edge 10 → `e_enable_br` rises at edge 18. `e_XY0_br` is {460, 210} if `lfsr[6]` was 0, else {460, 270}. `e_move_br` equals a model LFSR's `[5:0]` at edge 17.
- `done_move_br` high 5 cycles after enable → enable falls the next cycle, `spawn_cnt` = 1, outputs unchanged during ARM.
- `br_end` held high before ACTIVE, then low, then high at edge 100 → only the rise at edge 100 counts; enable rises at edge 108.
- Pause 20 cycles in mid-WAIT, then resume → enable is delayed by exactly 20 cycles. Pause during ARM → enable stays high and `done_move_br` is ignored until resume.
- `e_start_qb` while in ACTIVE → WAIT with `spawn_cnt` = 0 and enable after 8 cycles. `reset` low mid-ARM → all outputs are at reset values on the next edge.
- SPAWN_DELAY=0 → enable 1 cycle after WAIT entry. 300 spawn cycles → `spawn_cnt` saturates at 255.
